// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the 16-bit core's ID stage: opcodes, instruction
// field positions, NOP encoding and the ID/EX payload structure.
package id_stage_pkg;

   localparam int DW = 8;
   localparam int RN = 8;

   typedef enum logic [3:0] {
      OP_NOP  = 4'b0000,
      OP_ADD  = 4'b0001,
      OP_SUB  = 4'b0010,
      OP_AND  = 4'b0011,
      OP_OR   = 4'b0100,
      OP_XOR  = 4'b0101,
      OP_SL   = 4'b0110,
      OP_SR   = 4'b0111,
      OP_ADDI = 4'b1001,
      OP_LD   = 4'b1010,
      OP_ST   = 4'b1011,
      OP_BR   = 4'b1100
   } opcode_e;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 9;
   localparam int RS1_HI = 8;
   localparam int RS1_LO = 6;
   localparam int RS2_HI = 5;
   localparam int RS2_LO = 3;
   localparam int IMM_HI = 5;
   localparam int IMM_LO = 0;

   localparam logic [15:0] NOP_INSTR = 16'h0000;

   typedef struct packed {
      logic wb_en;
      logic mem_read;
      logic mem_write;
   } ctrl_t;

   typedef struct packed {
      logic [3:0]    op;
      logic [2:0]    dest;
      logic [2:0]    src1;
      logic [2:0]    src2;
      logic [DW-1:0] val1;
      logic [DW-1:0] val2;
      logic [DW-1:0] imm;
      ctrl_t         ctrl;
   } idex_t;

   function automatic logic [DW-1:0] sext_imm(input logic [5:0] imm6);
      return {{(DW-6){imm6[5]}}, imm6};
   endfunction

endpackage

// File: rtl/id_stage_if.sv
// Signal bundle between the ID stage and its neighbours (fetch, writeback, MEM, execute).
// The master side drives instructions and writeback; the slave side is the ID stage.
interface id_stage_if;
   import id_stage_pkg::*;

   logic [15:0]   instr;
   logic          wb_en;
   logic [2:0]    wb_dest;
   logic [DW-1:0] wb_data;
   logic          mem_wb_en;
   logic [2:0]    mem_dest;

   logic          stall;
   logic          branch_taken;
   logic [5:0]    branch_offset_imm;

   logic [3:0]    ex_op;
   logic [2:0]    ex_dest;
   logic [2:0]    ex_src1;
   logic [2:0]    ex_src2;
   logic [DW-1:0] ex_val1;
   logic [DW-1:0] ex_val2;
   logic [DW-1:0] ex_imm;
   logic          ex_wb_en;
   logic          ex_mem_read;
   logic          ex_mem_write;

   modport master (
      output instr, wb_en, wb_dest, wb_data, mem_wb_en, mem_dest,
      input  stall, branch_taken, branch_offset_imm,
      input  ex_op, ex_dest, ex_src1, ex_src2, ex_val1, ex_val2, ex_imm,
      input  ex_wb_en, ex_mem_read, ex_mem_write
   );

   modport slave (
      input  instr, wb_en, wb_dest, wb_data, mem_wb_en, mem_dest,
      output stall, branch_taken, branch_offset_imm,
      output ex_op, ex_dest, ex_src1, ex_src2, ex_val1, ex_val2, ex_imm,
      output ex_wb_en, ex_mem_read, ex_mem_write
   );

endinterface

// File: rtl/id_stage_reg_file.sv
// reg_file: N x W registers, two async read ports, one sync write port, R0 reads zero.
// Build option: ID_WB_BYPASS_EN makes a same-cycle write visible to the read ports.
module reg_file
   import id_stage_pkg::*;
#(
   parameter int W  = DW,
   parameter int N  = RN,
   parameter int AW = $clog2(N)
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] raddr1,
   input  logic [AW-1:0] raddr2,
   output logic [W-1:0]  rdata1,
   output logic [W-1:0]  rdata2,
   input  logic          wen,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata
);

   logic [W-1:0] regs_r [N];

   function automatic logic [W-1:0] read_port(input logic [AW-1:0] addr);
      logic [W-1:0] v;
      if (addr == {AW{1'b0}}) begin
         v = {W{1'b0}};
`ifdef ID_WB_BYPASS_EN
      end else if (wen && (waddr == addr)) begin
         v = wdata;
`endif
      end else begin
         v = regs_r[addr];
      end
      return v;
   endfunction

   // Write port; R0 is never stored so it stays zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            regs_r[i] <= {W{1'b0}};
         end
      end else if (wen && (waddr != {AW{1'b0}})) begin
         regs_r[waddr] <= wdata;
      end
   end

   // Asynchronous read ports.
   always_comb begin
      rdata1 = read_port(raddr1);
      rdata2 = read_port(raddr2);
   end

endmodule

// File: rtl/id_stage.sv
// id_stage: IF/ID register, register file, decoder, load-use/branch hazards, ID/EX register.
// Build option: ID_WB_BYPASS_EN (writeback write-through; no WB-stage branch stall).
module id_stage
   import id_stage_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   id_stage_if.slave bus
);

   logic [15:0]   ifid_r;
   idex_t         idex_r;
   idex_t         decoded_s;
   logic [3:0]    op_s;
   logic [2:0]    rd_s;
   logic [2:0]    rs1_s;
   logic [2:0]    rs2_s;
   logic [2:0]    raddr2_s;
   logic [5:0]    imm6_s;
   logic [DW-1:0] rdata1_s;
   logic [DW-1:0] rdata2_s;
   logic          use1_s;
   logic          use2_s;
   logic          is_br_s;
   logic          load_use_s;
   logic          wb_hazard_s;
   logic          br_hazard_s;
   logic          stall_s;
   logic          taken_s;

   assign op_s     = ifid_r[OP_HI:OP_LO];
   assign rd_s     = ifid_r[RD_HI:RD_LO];
   assign rs1_s    = ifid_r[RS1_HI:RS1_LO];
   assign rs2_s    = ifid_r[RS2_HI:RS2_LO];
   assign imm6_s   = ifid_r[IMM_HI:IMM_LO];
   // A store's data register sits in the rd field and is read through port 2.
   assign raddr2_s = (op_s == OP_ST) ? rd_s : rs2_s;

   reg_file #(.W(DW), .N(RN)) u_reg_file (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (rs1_s),
      .raddr2 (raddr2_s),
      .rdata1 (rdata1_s),
      .rdata2 (rdata2_s),
      .wen    (bus.wb_en),
      .waddr  (bus.wb_dest),
      .wdata  (bus.wb_data)
   );

   // Decode IF/ID into the ID/EX payload; unused source fields read as zero.
   always_comb begin
      decoded_s = '0;
      use1_s    = 1'b0;
      use2_s    = 1'b0;
      is_br_s   = 1'b0;
      case (op_s)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SL, OP_SR: begin
            decoded_s.op         = op_s;
            decoded_s.dest       = rd_s;
            decoded_s.ctrl.wb_en = (rd_s != 3'd0);
            use1_s               = 1'b1;
            use2_s               = 1'b1;
         end
         OP_ADDI, OP_LD: begin
            decoded_s.op            = op_s;
            decoded_s.dest          = rd_s;
            decoded_s.imm           = sext_imm(imm6_s);
            decoded_s.ctrl.wb_en    = (rd_s != 3'd0);
            decoded_s.ctrl.mem_read = (op_s == OP_LD);
            use1_s                  = 1'b1;
         end
         OP_ST: begin
            decoded_s.op             = op_s;
            decoded_s.imm            = sext_imm(imm6_s);
            decoded_s.ctrl.mem_write = 1'b1;
            use1_s                   = 1'b1;
            use2_s                   = 1'b1;
         end
         OP_BR: begin
            decoded_s.op  = op_s;
            decoded_s.imm = sext_imm(imm6_s);
            use1_s        = 1'b1;
            is_br_s       = 1'b1;
         end
         default: begin
            decoded_s = '0;
         end
      endcase
      decoded_s.src1 = use1_s ? rs1_s : 3'd0;
      decoded_s.src2 = use2_s ? raddr2_s : 3'd0;
      decoded_s.val1 = use1_s ? rdata1_s : {DW{1'b0}};
      decoded_s.val2 = use2_s ? rdata2_s : {DW{1'b0}};
   end

   assign load_use_s = idex_r.ctrl.mem_read && (idex_r.dest != 3'd0) &&
                       ((use1_s && (rs1_s == idex_r.dest)) ||
                        (use2_s && (raddr2_s == idex_r.dest)));

`ifdef ID_WB_BYPASS_EN
   assign wb_hazard_s = 1'b0;
`else
   assign wb_hazard_s = bus.wb_en && (bus.wb_dest == rs1_s);
`endif

   // The branch compares its register now, so any in-flight write to it must land first.
   assign br_hazard_s = is_br_s && (rs1_s != 3'd0) &&
                        ((idex_r.ctrl.wb_en && (idex_r.dest == rs1_s)) ||
                         (bus.mem_wb_en && (bus.mem_dest == rs1_s)) ||
                         wb_hazard_s);

   assign stall_s = load_use_s || br_hazard_s;
   assign taken_s = is_br_s && !stall_s && (rdata1_s == {DW{1'b0}});

   // Pipeline registers: stall holds IF/ID and bubbles ID/EX; a taken branch flushes both.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ifid_r <= NOP_INSTR;
         idex_r <= '0;
      end else if (stall_s) begin
         ifid_r <= ifid_r;
         idex_r <= '0;
      end else if (taken_s) begin
         ifid_r <= NOP_INSTR;
         idex_r <= '0;
      end else begin
         ifid_r <= bus.instr;
         idex_r <= decoded_s;
      end
   end

   assign bus.stall             = stall_s;
   assign bus.branch_taken      = taken_s;
   assign bus.branch_offset_imm = imm6_s;
   assign bus.ex_op             = idex_r.op;
   assign bus.ex_dest           = idex_r.dest;
   assign bus.ex_src1           = idex_r.src1;
   assign bus.ex_src2           = idex_r.src2;
   assign bus.ex_val1           = idex_r.val1;
   assign bus.ex_val2           = idex_r.val2;
   assign bus.ex_imm            = idex_r.imm;
   assign bus.ex_wb_en          = idex_r.ctrl.wb_en;
   assign bus.ex_mem_read       = idex_r.ctrl.mem_read;
   assign bus.ex_mem_write      = idex_r.ctrl.mem_write;

endmodule
